// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and sequencing controller for the 5-stage MIPS core.
// Decodes load-use hazards, taken-branch flushes and data-memory wait states
// into write-enable / flush / bubble controls for the PC and the IF/ID, ID/EX
// and EX/MEM pipeline registers, and keeps saturating performance counters.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   idex_memrd, idex_rt      load status / destination of the ID/EX instruction
//   ifid_rs, ifid_rt,
//   ifid_uses_rt             source operand fields of the IF/ID instruction
//   br_taken                 taken branch resolved in EX/MEM
//   dmem_req, dmem_rdy       data-memory access handshake of the MEM stage
//   pc_wr, ifid_wr           PC / IF/ID load enables          (combinational)
//   ifid_flush, idex_bubble,
//   exmem_flush              NOP / zero-control injection       (combinational)
//   freeze                   all pipeline registers hold        (combinational)
//   mem_err                  sticky memory-timeout flag         (registered)
//   stall_cnt, flush_cnt     saturating load-use / flush counts (registered)
//   state                    0=RUN, 1=WAIT, 2=ERR               (registered)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memrd,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_rdy,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam int              WC_W   = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu_s;
    logic mw_s;
    logic frozen_s;
    logic branch_s;
    logic stall_s;

    // Hazard conditions decoded from the current pipeline operand fields.
    always_comb begin
        lu_s = idex_memrd && (idex_rt != 5'd0) &&
               ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        mw_s = dmem_req && !dmem_rdy;
    end

    // FSM next state; also decides whether this cycle is a freeze cycle.
    // The RUN entry cycle of a wait already counts as freeze cycle 1, so
    // wait_cnt equals the number of freeze cycles completed before this one.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        frozen_s   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mw_s) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WC_ONE;
                    frozen_s   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            ST_WAIT: begin
                if (dmem_rdy) begin
                    // Access completes: pipeline moves this cycle.
                    state_d    = ST_RUN;
                    wait_cnt_d = {WC_W{1'b0}};
                end else begin
                    frozen_s = 1'b1;
                    if (wait_cnt_q == WC_MAX) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_ONE;
                    end
                end
            end
            ST_ERR: begin
                frozen_s = 1'b1;
            end
            default: begin
                // Unreachable encoding: fail safe into the error state.
                state_d   = ST_ERR;
                mem_err_d = 1'b1;
                frozen_s  = 1'b1;
            end
        endcase
    end

    // Pipeline control decode by priority: freeze > branch flush > load-use > normal.
    always_comb begin
        pc_wr       = 1'b0;
        ifid_wr     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        freeze      = 1'b0;
        branch_s    = 1'b0;
        stall_s     = 1'b0;
        if (frozen_s) begin
            freeze = 1'b1;
        end else if (br_taken) begin
            // Load-use is irrelevant: the dependent instruction is flushed.
            branch_s    = 1'b1;
            pc_wr       = 1'b1;
            ifid_wr     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (lu_s) begin
            stall_s     = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pc_wr   = 1'b1;
            ifid_wr = 1'b1;
        end
    end

    // Performance counter next values; only non-frozen cycles count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (branch_s) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, wait counter, error flag and counters; async reset returns to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= {WC_W{1'b0}};
            mem_err_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl (TIMEOUT=4, CNT_W=4): a table of
// directed vectors, hand-written multi-cycle sequences (memory wait, branch
// under wait, timeout, async reset, counter saturation) and a randomized run,
// all compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          idex_memrd;
    logic [4:0]    idex_rt;
    logic [4:0]    ifid_rs;
    logic [4:0]    ifid_rt;
    logic          ifid_uses_rt;
    logic          br_taken;
    logic          dmem_req;
    logic          dmem_rdy;
    logic          pc_wr;
    logic          ifid_wr;
    logic          ifid_flush;
    logic          idex_bubble;
    logic          exmem_flush;
    logic          freeze;
    logic          mem_err;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [1:0]    state;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .idex_memrd   (idex_memrd),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .br_taken     (br_taken),
        .dmem_req     (dmem_req),
        .dmem_rdy     (dmem_rdy),
        .pc_wr        (pc_wr),
        .ifid_wr      (ifid_wr),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .exmem_flush  (exmem_flush),
        .freeze       (freeze),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    // control vector order: {pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_flush, freeze}
    localparam logic [5:0] C_NORM  = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_FLUSH = 6'b111110;
    localparam logic [5:0] C_FRZ   = 6'b000001;

    typedef struct {
        logic       memrd;
        logic [4:0] irt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
        logic       req;
        logic       rdy;
        logic [5:0] exp_ctl;
        bit         has_exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_state;   // 0 RUN, 1 WAIT, 2 ERR
    int m_frz;     // freeze cycles already completed in the current wait
    int m_err;
    int m_stall;
    int m_flush;

    function automatic vec_t mk(input bit memrd, input int irt, input int rs, input int rt,
                                input bit uses, input bit br, input bit req, input bit rdy,
                                input logic [5:0] exp_ctl, input bit has_exp);
        vec_t v;
        v.memrd   = memrd;
        v.irt     = 5'(irt);
        v.rs      = 5'(rs);
        v.rt      = 5'(rt);
        v.uses    = uses;
        v.br      = br;
        v.req     = req;
        v.rdy     = rdy;
        v.exp_ctl = exp_ctl;
        v.has_exp = has_exp;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_frozen();
        bit waiting = dmem_req && !dmem_rdy;
        return (m_state == 2) || (m_state == 0 && waiting) || (m_state == 1 && !dmem_rdy);
    endfunction

    function automatic logic [5:0] model_ctl();
        bit lu;
        lu = idex_memrd && (idex_rt != 0) &&
             ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        if (model_frozen()) return C_FRZ;
        if (br_taken)       return C_FLUSH;
        if (lu)             return C_STALL;
        return C_NORM;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_frz   = 0;
        m_err   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Advance the model across one clock edge using the inputs held at that edge.
    task automatic model_update();
        logic [5:0] c;
        c = model_ctl();
        if (c == C_FLUSH && m_flush < CMAX) m_flush++;
        if (c == C_STALL && m_stall < CMAX) m_stall++;
        if (m_state == 0) begin
            if (dmem_req && !dmem_rdy) begin
                m_state = 1;
                m_frz   = 1;
            end
        end else if (m_state == 1) begin
            if (dmem_rdy) begin
                m_state = 0;
            end else if (m_frz + 1 == TO + 1) begin
                // this cycle was freeze cycle TIMEOUT+1
                m_state = 2;
                m_err   = 1;
            end else begin
                m_frz++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " ctl"}, int'({pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_flush, freeze}),
            int'(model_ctl()));
        chk({tag, " state"},     int'(state),     m_state);
        chk({tag, " mem_err"},   int'(mem_err),   m_err);
        chk({tag, " stall_cnt"}, int'(stall_cnt), m_stall);
        chk({tag, " flush_cnt"}, int'(flush_cnt), m_flush);
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        idex_memrd   = v.memrd;
        idex_rt      = v.irt;
        ifid_rs      = v.rs;
        ifid_rt      = v.rt;
        ifid_uses_rt = v.uses;
        br_taken     = v.br;
        dmem_req     = v.req;
        dmem_rdy     = v.rdy;
        #2;
        if (v.has_exp) begin
            chk({tag, " ctl_tbl"},
                int'({pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_flush, freeze}),
                int'(v.exp_ctl));
        end
        check_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        idex_memrd   = 1'b0;
        idex_rt      = 5'd0;
        ifid_rs      = 5'd0;
        ifid_rt      = 5'd0;
        ifid_uses_rt = 1'b0;
        br_taken     = 1'b0;
        dmem_req     = 1'b0;
        dmem_rdy     = 1'b0;
    endtask

    // Pulse reset between clock edges; registered state must clear with no edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        #1 rst = 1'b0;
        #1;
        chk({tag, " rst state"},   int'(state),     0);
        chk({tag, " rst mem_err"}, int'(mem_err),   0);
        chk({tag, " rst stall"},   int'(stall_cnt), 0);
        chk({tag, " rst flush"},   int'(flush_cnt), 0);
        chk({tag, " rst ctl"},
            int'({pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_flush, freeze}), int'(C_NORM));
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = mk(1, 5, 5, 0, 0, 0, 0, 0, C_STALL, 1); // load-use on rs
        tbl[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, C_NORM,  1); // r0 never hazards
        tbl[2] = mk(1, 7, 3, 7, 0, 0, 0, 0, C_NORM,  1); // rt match, rt unused
        tbl[3] = mk(1, 7, 3, 7, 1, 0, 0, 0, C_STALL, 1); // rt match, rt used
        tbl[4] = mk(1, 5, 5, 0, 0, 1, 0, 0, C_FLUSH, 1); // branch over load-use
        tbl[5] = mk(0, 5, 5, 5, 1, 0, 0, 0, C_NORM,  1); // not a load
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 1, 1, C_NORM,  1); // access ready at once
        tbl[7] = mk(0, 0, 0, 0, 0, 1, 0, 0, C_FLUSH, 1); // plain branch

        idle_inputs();
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset state",   int'(state),     0);
        chk("reset mem_err", int'(mem_err),   0);
        chk("reset stall",   int'(stall_cnt), 0);
        chk("reset flush",   int'(flush_cnt), 0);
        rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;

        // directed table
        for (int i = 0; i < 8; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end
        chk("tbl stall_cnt", int'(stall_cnt), 2);
        chk("tbl flush_cnt", int'(flush_cnt), 2);

        // memory wait of 3 cycles with a load-use pending; counters frozen
        for (int i = 0; i < 3; i++) begin
            step($sformatf("mw%0d", i), mk(1, 5, 5, 0, 0, 0, 1, 0, C_FRZ, 1));
            chk($sformatf("mw%0d state", i), int'(state), 1);
        end
        chk("mw stall frozen", int'(stall_cnt), 2);
        step("mw_rdy", mk(1, 5, 5, 0, 0, 0, 1, 1, C_STALL, 1));
        chk("mw_rdy state", int'(state), 0);
        chk("mw_rdy stall", int'(stall_cnt), 3);

        // branch under a memory wait is deferred to the ready cycle
        step("brw0", mk(0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 1));
        chk("brw0 flush held", int'(flush_cnt), 2);
        step("brw1", mk(0, 0, 0, 0, 0, 1, 1, 1, C_FLUSH, 1));
        chk("brw1 state", int'(state), 0);
        chk("brw1 flush", int'(flush_cnt), 3);

        // timeout: TIMEOUT+1 freeze cycles enter ERR
        for (int i = 0; i < 5; i++) begin
            step($sformatf("to%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1));
            if (i == 3) begin
                chk("to3 state", int'(state), 1);
                chk("to3 mem_err", int'(mem_err), 0);
            end
        end
        chk("to state err", int'(state), 2);
        chk("to mem_err",   int'(mem_err), 1);
        step("err_hold", mk(1, 5, 5, 0, 0, 1, 1, 1, C_FRZ, 1));
        chk("err_hold state", int'(state), 2);
        async_reset("to");

        // saturation of stall_cnt
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat%0d", i), mk(1, 9, 9, 0, 0, 0, 0, 0, C_STALL, 1));
        end
        chk("sat stall_cnt", int'(stall_cnt), CMAX);

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            if (i % 70 == 69) begin
                async_reset($sformatf("rnd%0d", i));
            end else begin
                step($sformatf("rnd%0d", i),
                     mk(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 1)), C_NORM, 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
